// File: rtl/upstream_word_packer.sv
`timescale 1ns/1ps
// upstream_word_packer
// Merges BD output words and FPGA report words into tagged 32-bit upstream
// words for the PipeOut FIFO. Output is grouped into BLOCK_WORDS-word blocks.
// A partial block that goes idle for TIMEOUT cycles, or that sees a flush
// request, is completed with nop words.
//
// Ports:
//   clk, reset_n          system clock, async active-low reset
//   bd_data/valid/ready   21-bit BD word input (ready/valid)
//   fpga_code/payload/valid/ready  FPGA report input (ready/valid)
//   flush                 single-cycle request to pad the current partial block
//   out_data/valid/ready  32-bit upstream word output (ready/valid)
//   nop_count             saturating count of nops emitted since reset
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | at a block boundary (word_idx==0), nothing pending, timer held 0
// FILL   | partial block open, timer measures idle cycles
// PAD    | emitting nops until the current block is complete
module upstream_word_packer #(
  parameter int BLOCK_WORDS = 4,
  parameter int TIMEOUT     = 256,
  parameter int TW          = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [20:0] bd_data,
  input  logic        bd_valid,
  output logic        bd_ready,
  input  logic [5:0]  fpga_code,
  input  logic [23:0] fpga_payload,
  input  logic        fpga_valid,
  output logic        fpga_ready,
  input  logic        flush,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] nop_count
);

  localparam int          IW       = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [31:0] NOP_WORD = {2'b10, 6'd63, 24'd1};

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PAD} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   word_idx_q, word_idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            rr_q, rr_d;          // 0: BD preferred, 1: FPGA preferred
  logic [15:0]     nop_count_q, nop_count_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_data_q, out_data_d;

  logic load, grant_bd, grant_fpga, grant, load_nop, word_load, block_done;

  always_comb begin
    load       = !out_valid_q || out_ready;
    grant_bd   = 1'b0;
    grant_fpga = 1'b0;
    if (load && state_q != S_PAD) begin
      if (!rr_q) begin
        if (bd_valid)        grant_bd   = 1'b1;
        else if (fpga_valid) grant_fpga = 1'b1;
      end else begin
        if (fpga_valid)      grant_fpga = 1'b1;
        else if (bd_valid)   grant_bd   = 1'b1;
      end
    end
    grant      = grant_bd || grant_fpga;
    load_nop   = load && (state_q == S_PAD);
    word_load  = grant || load_nop;
    block_done = word_load && (word_idx_q == IW'(BLOCK_WORDS - 1));
  end

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    timer_d     = timer_q;
    rr_d        = rr_q;
    nop_count_d = nop_count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (load) begin
      out_valid_d = word_load;
      if (grant_bd)        out_data_d = {2'b01, 9'd0, bd_data};
      else if (grant_fpga) out_data_d = {2'b10, fpga_code, fpga_payload};
      else if (load_nop)   out_data_d = NOP_WORD;
    end

    // BLOCK_WORDS is a power of two, so the index wraps naturally.
    if (word_load) word_idx_d = word_idx_q + IW'(1);
    if (grant)     rr_d       = grant_bd;
    if (load_nop && nop_count_q != 16'hFFFF) nop_count_d = nop_count_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (grant) state_d = S_FILL;
      end
      S_FILL: begin
        if (grant) begin
          // A coincident flush still lets the grant through first.
          timer_d = '0;
          if (block_done) state_d = S_IDLE;
          else if (flush) state_d = S_PAD;
        end else if (flush) begin
          timer_d = '0;
          state_d = S_PAD;
        end else if (load) begin
          // Only idle cycles with a free output stage count toward timeout.
          if (timer_q == TW'(TIMEOUT - 1)) begin
            timer_d = '0;
            state_d = S_PAD;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      S_PAD: begin
        timer_d = '0;
        if (block_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      word_idx_q  <= '0;
      timer_q     <= '0;
      rr_q        <= 1'b0;
      nop_count_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      timer_q     <= timer_d;
      rr_q        <= rr_d;
      nop_count_q <= nop_count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bd_ready   = grant_bd;
  assign fpga_ready = grant_fpga;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign nop_count  = nop_count_q;

`ifndef SYNTHESIS
  // Code 63 is reserved for nop; a source sending it would be forwarded as-is.
  a_no_reserved_code: assert property (@(posedge clk) disable iff (!reset_n)
    !(fpga_valid && fpga_ready && fpga_code == 6'd63))
    else $error("reserved fpga_code 63 accepted from source");
`endif

endmodule
